// File: rtl/ram_clear_pkg.sv
// Shared types and constants for the RAM clear / forwarding front end.
// Imported by ram_clear_port.
package ram_clear_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    PASS  = 1'b1
  } clr_state_t;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/ram_clear_port.sv
// Registered front end for dpram port 1: sweeps every address with FILL after reset
// or on clr_req, otherwise forwards the core's request through one register stage.
module ram_clear_port
  import ram_clear_pkg::*;
#(
  parameter int unsigned AW   = 16,
  parameter logic [7:0]  FILL = FILL_DEFAULT
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic          clr_req,
  input  logic [AW-1:0] core_ad,
  input  logic [7:0]    core_d,
  input  logic          core_cs,
  input  logic          core_we,
  output logic [AW-1:0] ram_ad,
  output logic [7:0]    ram_d,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          clr_busy,
  output logic          clr_done
);

  clr_state_t    r_state;
  clr_state_t    w_next_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_ram_ad;
  logic [7:0]    r_ram_d;
  logic          r_ram_cs;
  logic          r_ram_we;
  logic          r_clr_busy;
  logic          r_clr_done;
  logic          w_cnt_last;

  assign w_cnt_last = (r_cnt == {AW{1'b1}});

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // clr_req is deliberately ignored while sweeping: a sweep always runs to completion.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLEAR: if (w_cnt_last) w_next_state = PASS;
      PASS:  if (clr_req)    w_next_state = CLEAR;
      default: w_next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_clr_busy <= 1'b1;
      r_clr_done <= 1'b0;
      r_ram_ad   <= '0;
      r_ram_d    <= FILL;
      r_ram_cs   <= 1'b0;
      r_ram_we   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_ram_ad <= r_cnt;
          r_ram_d  <= FILL;
          r_ram_cs <= 1'b1;
          r_ram_we <= 1'b1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_cnt_last) begin
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_clr_done <= 1'b0;
          end
        end
        PASS: begin
          r_clr_done <= 1'b0;
          if (clr_req) begin
            // One idle gap edge: the core request presented on this edge is dropped.
            r_cnt      <= '0;
            r_clr_busy <= 1'b1;
            r_ram_cs   <= 1'b0;
            r_ram_we   <= 1'b0;
          end else begin
            r_ram_ad <= core_ad;
            r_ram_d  <= core_d;
            r_ram_cs <= core_cs;
            r_ram_we <= core_we;
          end
        end
        default: begin
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign ram_ad   = r_ram_ad;
  assign ram_d    = r_ram_d;
  assign ram_cs   = r_ram_cs;
  assign ram_we   = r_ram_we;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

endmodule

// File: tb/tb_ram_clear_port.sv
// Scoreboard bench for ram_clear_port: a small AW=4 instance under random stimulus and
// a default AW=16 instance for the full-size sweep length.
module tb_ram_clear_port;

  localparam int SAW = 4;
  localparam int SN  = 1 << SAW;
  localparam logic [7:0] SFILL = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_s, clr_req_s, core_cs_s, core_we_s;
  logic [SAW-1:0] core_ad_s, ram_ad_s;
  logic [7:0]     core_d_s, ram_d_s;
  logic           ram_cs_s, ram_we_s, busy_s, done_s;

  logic           rst_b;
  logic [15:0]    ram_ad_b;
  logic [7:0]     ram_d_b;
  logic           ram_cs_b, ram_we_b, busy_b, done_b;

  ram_clear_port #(.AW(SAW), .FILL(SFILL)) u_small (
    .clk_48(clk), .reset(rst_s), .clr_req(clr_req_s),
    .core_ad(core_ad_s), .core_d(core_d_s), .core_cs(core_cs_s), .core_we(core_we_s),
    .ram_ad(ram_ad_s), .ram_d(ram_d_s), .ram_cs(ram_cs_s), .ram_we(ram_we_s),
    .clr_busy(busy_s), .clr_done(done_s)
  );

  ram_clear_port u_big (
    .clk_48(clk), .reset(rst_b), .clr_req(1'b0),
    .core_ad(16'h0000), .core_d(8'h00), .core_cs(1'b0), .core_we(1'b0),
    .ram_ad(ram_ad_b), .ram_d(ram_d_b), .ram_cs(ram_cs_b), .ram_we(ram_we_b),
    .clr_busy(busy_b), .clr_done(done_b)
  );

  // dpram port 1 stand-ins, with a registered read port for the small instance
  logic [7:0] mem_s [SN];
  logic [7:0] mem_b [65536];
  logic [7:0] ram_q_s;

  always @(posedge clk) begin
    if (ram_cs_s && ram_we_s) mem_s[ram_ad_s] <= ram_d_s;
    if (ram_cs_s && !ram_we_s) ram_q_s <= mem_s[ram_ad_s];
    if (ram_cs_b && ram_we_b) mem_b[ram_ad_b] <= ram_d_b;
  end

  typedef struct {
    logic [SAW-1:0] ad;
    logic [7:0]     d;
    logic           cs, we, busy, done;
    bit             chk_ad;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [SN];
  int         sweep_left;
  int         sweep_addr;
  bit         rel_pending;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model: a sweep is just "sweep_left writes of SFILL starting at sweep_addr".
  task automatic model_push(input bit req, input logic [SAW-1:0] ad, input logic [7:0] d,
                            input logic cs, input logic we);
    exp_t e;
    e.chk_ad = 1'b1;
    if (sweep_left > 0) begin
      e.ad = sweep_addr[SAW-1:0];
      e.d  = SFILL;
      e.cs = 1'b1;
      e.we = 1'b1;
      ref_mem[sweep_addr] = SFILL;
      sweep_addr = sweep_addr + 1;
      sweep_left = sweep_left - 1;
      e.busy = (sweep_left != 0);
      e.done = (sweep_left == 0);
    end else if (req) begin
      e.chk_ad = 1'b0;
      e.ad = '0;
      e.d  = '0;
      e.cs = 1'b0;
      e.we = 1'b0;
      e.busy = 1'b1;
      e.done = 1'b0;
      sweep_left = SN;
      sweep_addr = 0;
    end else begin
      e.ad = ad;
      e.d  = d;
      e.cs = cs;
      e.we = we;
      e.busy = 1'b0;
      e.done = 1'b0;
      if (cs && we) ref_mem[ad] = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    sweep_left = SN;
    sweep_addr = 0;
    exp_q.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step_core(input bit req, input logic [SAW-1:0] ad, input logic [7:0] d,
                           input logic cs, input logic we);
    @(negedge clk);
    if (rel_pending) begin
      rst_s = 1'b0;
      rel_pending = 1'b0;
    end
    clr_req_s = req;
    core_ad_s = ad;
    core_d_s  = d;
    core_cs_s = cs;
    core_we_s = we;
    model_push(req, ad, d, cs, we);
  endtask

  task automatic step_rand(input bit req);
    step_core(req, SAW'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic settle();
    repeat (2) step_core(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic mem_check(input string tag);
    for (int a = 0; a < SN; a++) chk($sformatf("%s_mem%0d", tag, a), 32'(mem_s[a]), 32'(ref_mem[a]));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_ad"},   32'(ram_ad_s), 32'(0));
    chk({tag, "_d"},    32'(ram_d_s),  32'(SFILL));
    chk({tag, "_cs"},   32'(ram_cs_s), 32'(0));
    chk({tag, "_we"},   32'(ram_we_s), 32'(0));
    chk({tag, "_busy"}, 32'(busy_s),   32'(1));
    chk({tag, "_done"}, 32'(done_s),   32'(0));
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (ram_cs_s !== e.cs || ram_we_s !== e.we || busy_s !== e.busy || done_s !== e.done ||
            (e.chk_ad && (ram_ad_s !== e.ad || ram_d_s !== e.d))) begin
          n_fail++;
          $display("FAIL out t=%0t got ad=%h d=%h cs=%b we=%b busy=%b done=%b want ad=%h d=%h cs=%b we=%b busy=%b done=%b (ad/d checked=%0d)",
                   $time, ram_ad_s, ram_d_s, ram_cs_s, ram_we_s, busy_s, done_s,
                   e.ad, e.d, e.cs, e.we, e.busy, e.done, e.chk_ad);
        end
      end
    end
  endtask

  task automatic small_test();
    rst_s = 1'b1;
    clr_req_s = 1'b0;
    core_ad_s = '0;
    core_d_s = '0;
    core_cs_s = 1'b0;
    core_we_s = 1'b0;
    model_reset();
    #12;
    reset_check("rst");
    rel_pending = 1'b1;
    repeat (SN) step_rand(1'b0);
    settle();
    mem_check("sweep0");

    step_core(1'b0, 4'd7, 8'h3C, 1'b1, 1'b1);
    step_core(1'b0, 4'd7, 8'h00, 1'b1, 1'b0);
    step_core(1'b0, '0, '0, 1'b0, 1'b0);
    step_core(1'b0, '0, '0, 1'b0, 1'b0);
    chk("read7", 32'(ram_q_s), 32'h3C);

    repeat (40) step_rand(1'b0);
    step_core(1'b1, 4'd2, 8'($urandom), 1'b1, 1'b1);
    repeat (SN + 1) step_rand(1'b0);
    repeat (20) step_rand(1'b1);
    repeat (20) step_rand(1'b0);
    settle();
    mem_check("hold");

    repeat (200) step_rand($urandom_range(0, 49) == 0);
    repeat (SN + 4) step_rand(1'b0);

    step_rand(1'b1);
    repeat (9) step_rand(1'b0);
    @(posedge clk);
    #3;
    rst_s = 1'b1;
    model_reset();
    #1;
    reset_check("midrst");
    rel_pending = 1'b1;
    repeat (SN + 4) step_rand(1'b0);
    settle();
    mem_check("restart");
  endtask

  task automatic big_test();
    int n;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    while (n < 70000) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy_b) break;
    end
    chk("big_busy_edges", 32'(n), 32'd65536);
    chk("big_done_pulse", 32'(done_b), 32'd1);
    chk("big_last_ad", 32'(ram_ad_b), 32'hFFFF);
    @(posedge clk);
    #1;
    chk("big_done_clear", 32'(done_b), 32'd0);
    chk("big_mem0000", 32'(mem_b[16'h0000]), 32'hFF);
    chk("big_mem8000", 32'(mem_b[16'h8000]), 32'hFF);
    chk("big_memFFFF", 32'(mem_b[16'hFFFF]), 32'hFF);
  endtask

  initial begin
    rel_pending = 1'b0;
    fork
      monitor_loop();
    join_none
    fork
      small_test();
      big_test();
    join
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
